// File: rtl/camera_pkg.sv
// Shared camera-path definitions: pixel format, output address widths and the
// frame-acceptance state encoding used by the 3x3 window generator.
package camera_pkg;

    localparam int PIXEL_W = 12;
    localparam int XADDR_W = 10;
    localparam int YADDR_W = 9;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb444_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } frame_state_t;

endpackage

// File: rtl/pixel_window_3x3_if.sv
// Pixel stream in / 3x3 window out bundle. The window generator is the slave;
// the upstream pixel source and downstream resolver sit on the master side.
interface pixel_window_3x3_if;
    import camera_pkg::*;

    logic                 frameStart;
    logic                 pixelValid;
    pixel_t               pixelIn;
    pixel_t               outPixel_lu, outPixel_lm, outPixel_ld;
    pixel_t               outPixel_mu, outPixel_mm, outPixel_md;
    pixel_t               outPixel_ru, outPixel_rm, outPixel_rd;
    logic [XADDR_W-1:0]   xAddr;
    logic [YADDR_W-1:0]   yAddr;
    logic                 windowValid;
    logic                 frameOverrun;

    modport master (
        output frameStart, pixelValid, pixelIn,
        input  outPixel_lu, outPixel_lm, outPixel_ld,
        input  outPixel_mu, outPixel_mm, outPixel_md,
        input  outPixel_ru, outPixel_rm, outPixel_rd,
        input  xAddr, yAddr, windowValid, frameOverrun
    );

    modport slave (
        input  frameStart, pixelValid, pixelIn,
        output outPixel_lu, outPixel_lm, outPixel_ld,
        output outPixel_mu, outPixel_mm, outPixel_md,
        output outPixel_ru, outPixel_rm, outPixel_rd,
        output xAddr, yAddr, windowValid, frameOverrun
    );

endinterface

// File: rtl/line_buffer.sv
// One line of pixels as a synchronous-read RAM. A read of the address being
// written in the same cycle returns the contents from before the write.
module line_buffer
    import camera_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output pixel_t        rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  pixel_t        wr_data
);

    pixel_t mem_r [DEPTH];

    // Array write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds the last word between reads
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/pixel_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a three-column
// window emit every interior pixel's neighbourhood two cycles after its trigger.
module pixel_window_3x3
    import camera_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic               clk25,
    input  logic               rst_n,
    pixel_window_3x3_if.slave  win
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);

    frame_state_t   state_r, state_s;
    logic [XW-1:0]  x_r, x_s, beat_x_s, p1_x_r;
    logic [YW-1:0]  y_r, y_s, beat_y_s, p1_y_r;
    logic           overrun_r, overrun_s, accept_s, emit_s;
    logic           p1_valid_r, p1_emit_r;
    pixel_t         p1_pix_r, row_a_s, row_b_s;
    pixel_t         top_r [2];
    pixel_t         mid_r [2];
    pixel_t         bot_r [2];
    pixel_t         lu_r, lm_r, ld_r, mu_r, mm_r, md_r, ru_r, rm_r, rd_r;
    logic [XADDR_W-1:0] xaddr_r;
    logic [YADDR_W-1:0] yaddr_r;
    logic           window_valid_r;

    // Beat acceptance, raster position of the beat and next frame state
    always_comb begin
        state_s   = state_r;
        x_s       = x_r;
        y_s       = y_r;
        overrun_s = overrun_r;
        accept_s  = 1'b0;
        beat_x_s  = x_r;
        beat_y_s  = y_r;
        if (win.pixelValid && win.frameStart) begin
            accept_s  = 1'b1;
            beat_x_s  = '0;
            beat_y_s  = '0;
            x_s       = XW'(1);
            y_s       = '0;
            overrun_s = 1'b0;
            state_s   = ST_ACTIVE;
        end else if (win.pixelValid) begin
            case (state_r)
                ST_ACTIVE: begin
                    accept_s = 1'b1;
                    if (x_r == X_LAST) begin
                        x_s = '0;
                        y_s = y_r + YW'(1);
                        if (y_r == Y_LAST) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_ACTIVE;
                        end
                    end else begin
                        x_s = x_r + XW'(1);
                    end
                end
                ST_DONE:  overrun_s = 1'b1;
                default:  state_s = state_r;
            endcase
        end else begin
            state_s = state_r;
        end
        emit_s = accept_s && (beat_x_s >= X_TWO) && (beat_y_s >= Y_TWO);
    end

    // Frame state, next-beat coordinates and sticky overrun flag
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            x_r       <= '0;
            y_r       <= '0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            x_r       <= x_s;
            y_r       <= y_s;
            overrun_r <= overrun_s;
        end
    end

    // RAM-read stage: carries the beat alongside the line-buffer reads
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid_r <= 1'b0;
            p1_emit_r  <= 1'b0;
            p1_x_r     <= '0;
            p1_y_r     <= '0;
            p1_pix_r   <= '0;
        end else begin
            p1_valid_r <= accept_s;
            p1_emit_r  <= emit_s;
            p1_x_r     <= beat_x_s;
            p1_y_r     <= beat_y_s;
            p1_pix_r   <= win.pixelIn;
        end
    end

    // B is written one cycle after A is read, so A's old row lands in B at the same column
    line_buffer #(.DEPTH(IMG_WIDTH)) u_line_a (
        .clk(clk25), .rd_en(accept_s), .rd_addr(beat_x_s), .rd_data(row_a_s),
        .wr_en(accept_s), .wr_addr(beat_x_s), .wr_data(win.pixelIn)
    );

    line_buffer #(.DEPTH(IMG_WIDTH)) u_line_b (
        .clk(clk25), .rd_en(accept_s), .rd_addr(beat_x_s), .rd_data(row_b_s),
        .wr_en(p1_valid_r), .wr_addr(p1_x_r), .wr_data(row_a_s)
    );

    // Column history (two older columns; the incoming column completes the window) and output register
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            top_r <= '{default: '0};
            mid_r <= '{default: '0};
            bot_r <= '{default: '0};
            lu_r <= '0; lm_r <= '0; ld_r <= '0;
            mu_r <= '0; mm_r <= '0; md_r <= '0;
            ru_r <= '0; rm_r <= '0; rd_r <= '0;
            xaddr_r        <= '0;
            yaddr_r        <= '0;
            window_valid_r <= 1'b0;
        end else begin
            window_valid_r <= p1_valid_r && p1_emit_r;
            if (p1_valid_r) begin
                top_r[0] <= top_r[1]; top_r[1] <= row_b_s;
                mid_r[0] <= mid_r[1]; mid_r[1] <= row_a_s;
                bot_r[0] <= bot_r[1]; bot_r[1] <= p1_pix_r;
                if (p1_emit_r) begin
                    lu_r <= top_r[0]; mu_r <= top_r[1]; ru_r <= row_b_s;
                    lm_r <= mid_r[0]; mm_r <= mid_r[1]; rm_r <= row_a_s;
                    ld_r <= bot_r[0]; md_r <= bot_r[1]; rd_r <= p1_pix_r;
                    xaddr_r <= XADDR_W'(p1_x_r - XW'(1));
                    yaddr_r <= YADDR_W'(p1_y_r - YW'(1));
                end
            end
        end
    end

    assign win.outPixel_lu  = lu_r;
    assign win.outPixel_lm  = lm_r;
    assign win.outPixel_ld  = ld_r;
    assign win.outPixel_mu  = mu_r;
    assign win.outPixel_mm  = mm_r;
    assign win.outPixel_md  = md_r;
    assign win.outPixel_ru  = ru_r;
    assign win.outPixel_rm  = rm_r;
    assign win.outPixel_rd  = rd_r;
    assign win.xAddr        = xaddr_r;
    assign win.yAddr        = yaddr_r;
    assign win.windowValid  = window_valid_r;
    assign win.frameOverrun = overrun_r;

endmodule

// File: tb/tb_pixel_window_3x3.sv
// Directed bench for pixel_window_3x3 on an 8x6 frame: a raster model predicts
// every window and its arrival cycle; a negedge monitor compares against a queue.
module tb_pixel_window_3x3;
    import camera_pkg::*;

    localparam int W = 8;
    localparam int H = 6;
    localparam int WIN_PER_FRAME = 24;

    typedef struct {
        int           cyc;
        logic [126:0] data;
    } exp_t;

    logic clk25 = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   win_seen = 0;
    exp_t sb[$];

    int          m_state = 0;
    int          m_x = 0;
    int          m_y = 0;
    logic [11:0] img [H][W];

    logic [126:0] obs;

    pixel_window_3x3_if bus();

    pixel_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk25(clk25),
        .rst_n(rst_n),
        .win(bus)
    );

    assign obs = {bus.outPixel_lu, bus.outPixel_lm, bus.outPixel_ld,
                  bus.outPixel_mu, bus.outPixel_mm, bus.outPixel_md,
                  bus.outPixel_ru, bus.outPixel_rm, bus.outPixel_rd,
                  bus.xAddr, bus.yAddr};

    always #5 clk25 = ~clk25;

    always @(posedge clk25) cyc <= cyc + 1;

    function automatic logic [11:0] pv(input int x, input int y);
        return 12'((y * 16) + x);
    endfunction

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference behaviour of one accepted-or-dropped beat, evaluated when the beat is driven
    task automatic model_beat(input bit fs, input logic [11:0] pix);
        int bx;
        int by;
        bit acc;
        acc = 1'b0;
        bx  = 0;
        by  = 0;
        if (fs) begin
            acc = 1'b1;
            m_state = 1;
            m_x = 1;
            m_y = 0;
        end else if (m_state == 1) begin
            acc = 1'b1;
            bx  = m_x;
            by  = m_y;
            if (m_x == W - 1) begin
                m_x = 0;
                if (m_y == H - 1) m_state = 2;
                m_y = m_y + 1;
            end else begin
                m_x = m_x + 1;
            end
        end
        if (acc) begin
            img[by][bx] = pix;
            if (bx >= 2 && by >= 2) begin
                exp_t e;
                e.cyc  = cyc + 2;
                e.data = {img[by-2][bx-2], img[by-1][bx-2], img[by][bx-2],
                          img[by-2][bx-1], img[by-1][bx-1], img[by][bx-1],
                          img[by-2][bx],   img[by-1][bx],   img[by][bx],
                          10'(bx - 1), 9'(by - 1)};
                sb.push_back(e);
            end
        end
    endtask

    task automatic tick(input bit fs, input bit vld, input logic [11:0] pix);
        @(negedge clk25);
        bus.frameStart = fs;
        bus.pixelValid = vld;
        bus.pixelIn    = pix;
        if (vld) model_beat(fs, pix);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 12'h000);
    endtask

    // Raster beats first..first+n-1 of a frame; frameStart rides on index 0
    task automatic send_range(input int first, input int n, input int gap);
        for (int k = first; k < first + n; k++) begin
            tick(k == 0, 1'b1, pv(k % W, k / W));
            if (gap > 0) idle(gap);
        end
    endtask

    // Monitor: every cycle, windowValid must match the queue head, and data must match on a hit
    initial begin
        bit   exp_v;
        exp_t e;
        forever begin
            @(negedge clk25);
            exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
            n_total++;
            assert (bus.windowValid === exp_v) n_pass++;
            else begin
                n_fail++;
                $error("FAIL windowValid cyc=%0d observed=%b expected=%b", cyc, bus.windowValid, exp_v);
            end
            if (bus.windowValid === 1'b1) win_seen++;
            if (exp_v) begin
                e = sb.pop_front();
                n_total++;
                assert (obs === e.data) n_pass++;
                else begin
                    n_fail++;
                    $error("FAIL window_data cyc=%0d observed=%h expected=%h", cyc, obs, e.data);
                end
            end
        end
    end

    initial begin
        bus.frameStart = 1'b0;
        bus.pixelValid = 1'b0;
        bus.pixelIn    = 12'h000;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) img[y][x] = 12'h000;

        idle(3);
        check("reset_window", {1'b0, obs}, 128'h0);
        check("reset_flags", {bus.windowValid, bus.frameOverrun}, 128'h0);
        @(negedge clk25);
        rst_n = 1'b1;
        check("after_release_window", {1'b0, obs}, 128'h0);

        // Beats without frameStart are dropped in IDLE
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 12'hABC);
        idle(3);
        check("idle_drop_count", win_seen, 0);

        // Back-to-back frame
        win_seen = 0;
        send_range(0, W * H, 0);
        idle(3);
        check("b2b_window_count", win_seen, WIN_PER_FRAME);
        check("b2b_no_overrun", bus.frameOverrun, 0);

        // Same frame with a gap after every beat
        win_seen = 0;
        send_range(0, W * H, 1);
        idle(3);
        check("gapped_window_count", win_seen, WIN_PER_FRAME);

        // One beat beyond the frame sets the sticky overrun and emits nothing
        win_seen = 0;
        send_range(0, W * H, 0);
        tick(1'b0, 1'b1, 12'hFFF);
        idle(3);
        check("overrun_set", bus.frameOverrun, 1);
        check("overrun_window_count", win_seen, WIN_PER_FRAME);

        // New frameStart clears overrun; that frame is then cut short by frameStart at (5,3)
        win_seen = 0;
        send_range(0, 1, 0);
        idle(1);
        check("overrun_cleared", bus.frameOverrun, 0);
        send_range(1, 3 * W + 4, 0);
        send_range(0, W * H, 0);
        idle(3);
        check("restart_window_count", win_seen, 9 + WIN_PER_FRAME);
        check("restart_no_overrun", bus.frameOverrun, 0);

        // Reset in the middle of a frame discards in-flight windows
        send_range(0, 3 * W + 6, 0);
        idle(1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        m_state = 0;
        m_x = 0;
        m_y = 0;
        #1;
        check("midreset_window", {1'b0, obs}, 128'h0);
        check("midreset_flags", {bus.windowValid, bus.frameOverrun}, 128'h0);
        @(negedge clk25);
        rst_n = 1'b1;
        win_seen = 0;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, pv(i % W, 3));
        idle(3);
        check("postreset_drop_count", win_seen, 0);
        send_range(0, W * H, 0);
        idle(4);
        check("postreset_window_count", win_seen, WIN_PER_FRAME);
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
